sd_response_stream: RTL and testbench



---
 rtl/sd_response_stream.sv | 172 +++++++++++++++++
 tb/tb_sd_response_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_response_stream.sv
// rtl/sd_response_stream.sv - SD card CMD-line response frame transmitter
//
// Serialises a 48-bit SD response frame on the CMD line:
// start bit, transmission bit, 38-bit payload, CRC7, end bit.
// Line changes are made only on detected falling sd_clock edges, so the
// host can sample on rising edges.
//
// Optional feature macro: SD_RESP_NO_CRC_EN (adds no_crc input; when latched
// high, bits 7:1 are sent as all ones instead of CRC7, as for R3).
//
// Ports:
//   clock          system clock, sole clock domain
//   reset_n        asynchronous active-low reset
//   sd_clock       raw SD clock, synchronised internally
//   write_enabled  0 aborts any frame and holds the block idle
//   start          1-cycle request, payload latched this cycle
//   no_crc         (SD_RESP_NO_CRC_EN only) send 7'h7F in place of CRC7
//   data           payload {cmd_index[5:0], arg[31:0]}, frame bits 45:8
//   sd_serial_out  CMD line drive value
//   sd_serial_oe   CMD line output enable
//   busy           frame in progress
//   done           1-cycle pulse when the frame completes and the line is released

module sd_response_stream #(
  parameter int unsigned NCR_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sd_clock,
  input  logic        write_enabled,
  input  logic        start,
`ifdef SD_RESP_NO_CRC_EN
  input  logic        no_crc,
`endif
  input  logic [37:0] data,
  output logic        sd_serial_out,
  output logic        sd_serial_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_NCR,
    ST_SEND,
    ST_RELEASE
  } state_t;

  state_t      state;
  logic        sd_clock1;
  logic        sd_clock2;
  logic        sd_clock3;
  logic        fall;
  logic [37:0] payload;
  logic        no_crc_q;
  logic [3:0]  ncr_cnt;
  logic [5:0]  idx;
  logic [6:0]  crc;
  logic        send_bit;
  logic [38:0] frame_hi;
  logic [2:0]  crc_sel;

  assign fall = sd_clock3 && !sd_clock2;

  // Frame bits 46..8: transmission bit followed by the latched payload.
  assign frame_hi = {1'b0, payload};
  assign crc_sel  = idx[2:0] - 3'd1;

  // Bit to drive for frame position idx (used in ST_SEND).
  always_comb begin
    send_bit = 1'b1;
    if (idx >= 6'd8) begin
      send_bit = frame_hi[idx - 6'd8];
    end else if (idx != 6'd0) begin
      send_bit = no_crc_q ? 1'b1 : crc[crc_sel];
    end
  end

  // One serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      sd_clock1     <= 1'b0;
      sd_clock2     <= 1'b0;
      sd_clock3     <= 1'b0;
      payload       <= '0;
      no_crc_q      <= 1'b0;
      ncr_cnt       <= '0;
      idx           <= '0;
      crc           <= '0;
      sd_serial_out <= 1'b1;
      sd_serial_oe  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      sd_clock1 <= sd_clock;
      sd_clock2 <= sd_clock1;
      sd_clock3 <= sd_clock2;
      done      <= 1'b0;
      if (!write_enabled) begin
        // Abort takes priority over everything and never produces done.
        state         <= ST_IDLE;
        sd_serial_oe  <= 1'b0;
        sd_serial_out <= 1'b1;
        busy          <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sd_serial_oe  <= 1'b0;
            sd_serial_out <= 1'b1;
            if (start) begin
              payload <= data;
`ifdef SD_RESP_NO_CRC_EN
              no_crc_q <= no_crc;
`else
              no_crc_q <= 1'b0;
`endif
              ncr_cnt <= 4'(NCR_CYCLES);
              crc     <= '0;
              busy    <= 1'b1;
              state   <= ST_WAIT_NCR;
            end
          end
          ST_WAIT_NCR: begin
            if (fall) begin
              if (ncr_cnt == 4'd0) begin
                sd_serial_out <= 1'b0;
                sd_serial_oe  <= 1'b1;
                crc           <= crc_step(crc, 1'b0);
                idx           <= 6'd46;
                state         <= ST_SEND;
              end else begin
                ncr_cnt <= ncr_cnt - 4'd1;
              end
            end
          end
          ST_SEND: begin
            if (fall) begin
              sd_serial_out <= send_bit;
              // CRC covers frame bits 47..8 only; it is frozen while sent.
              if (idx >= 6'd8) begin
                crc <= crc_step(crc, send_bit);
              end
              if (idx == 6'd0) begin
                state <= ST_RELEASE;
              end else begin
                idx <= idx - 6'd1;
              end
            end
          end
          ST_RELEASE: begin
            if (fall) begin
              sd_serial_oe  <= 1'b0;
              sd_serial_out <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_response_stream.sv
// tb/tb_sd_response_stream.sv - directed self-checking bench for sd_response_stream

module tb_sd_response_stream;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_clock = 1'b0;
  logic        we = 1'b1;
  logic        start_r = 1'b0;
  logic        sel = 1'b0;
  logic        no_crc = 1'b0;
  logic [37:0] data = '0;
  logic        out1, oe1, busy1, done1;
  logic        out2, oe2, busy2, done2;
  logic        start1, start2;
  logic        m_out, m_oe, m_busy;
  int          done_cnt1 = 0;
  int          done_cnt2 = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [47:0] R7_FRAME    = 48'h08_0000_01AA_13;
  localparam logic [37:0] R7_DATA     = {6'd8, 32'h000001AA};
  localparam logic [47:0] R3_FRAME    = 48'h3F_80FF_8000_FF;
  localparam logic [37:0] R3_DATA     = {6'h3F, 32'h80FF8000};

  assign start1 = start_r && !sel;
  assign start2 = start_r && sel;
  assign m_out  = sel ? out2 : out1;
  assign m_oe   = sel ? oe2 : oe1;
  assign m_busy = sel ? busy2 : busy1;

  sd_response_stream #(.NCR_CYCLES(2)) dut_ncr2 (
    .clock         (clock),
    .reset_n       (reset_n),
    .sd_clock      (sd_clock),
    .write_enabled (we),
    .start         (start1),
`ifdef SD_RESP_NO_CRC_EN
    .no_crc        (no_crc),
`endif
    .data          (data),
    .sd_serial_out (out1),
    .sd_serial_oe  (oe1),
    .busy          (busy1),
    .done          (done1)
  );

  sd_response_stream #(.NCR_CYCLES(0)) dut_ncr0 (
    .clock         (clock),
    .reset_n       (reset_n),
    .sd_clock      (sd_clock),
    .write_enabled (we),
    .start         (start2),
`ifdef SD_RESP_NO_CRC_EN
    .no_crc        (no_crc),
`endif
    .data          (data),
    .sd_serial_out (out2),
    .sd_serial_oe  (oe2),
    .busy          (busy2),
    .done          (done2)
  );

  always #5 clock = ~clock;
  always #40 sd_clock = ~sd_clock;

  always @(negedge clock) begin
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [37:0] d, input logic nc);
    logic [6:0] c;
    c = nc ? 7'h7F : ref_crc7({2'b00, d});
    return {2'b00, d, c, 1'b1};
  endfunction

  function automatic int done_count();
    return sel ? done_cnt2 : done_cnt1;
  endfunction

  // inject_kind: 0 none, 1 second start after frame bit inject_bit, 2 drop write_enabled there.
  task automatic send_frame(input logic s, input logic [37:0] d, input logic nc,
                            input int inject_bit, input int inject_kind,
                            output logic [47:0] frame, output logic [47:0] exp,
                            output int falls, output int oe_bad);
    sel = s;
    exp = make_frame(d, nc);
    @(posedge sd_clock);
    #1;
    data    = d;
    no_crc  = nc;
    start_r = 1'b1;
    @(posedge clock);
    #1;
    start_r = 1'b0;
    falls = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sd_clock);
      #32;
      if (m_oe) begin
        falls = k;
        break;
      end
    end
    frame  = '0;
    oe_bad = 0;
    if (falls != 0) begin
      for (int b = 47; b >= 0; b--) begin
        @(posedge sd_clock);
        #1;
        frame[b] = m_out;
        if (!m_oe) oe_bad++;
        if (b == inject_bit && inject_kind == 1) begin
          data    = {6'd55, 32'h0};
          start_r = 1'b1;
          @(posedge clock);
          #1;
          start_r = 1'b0;
        end
        if (b == inject_bit && inject_kind == 2) begin
          we = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic check_release(input string tag, input int done_before);
    @(negedge sd_clock);
    #32;
    check_eq({tag, "_rel_oe"}, 64'(m_oe), 64'd0);
    check_eq({tag, "_rel_out"}, 64'(m_out), 64'd1);
    check_eq({tag, "_rel_busy"}, 64'(m_busy), 64'd0);
    check_eq({tag, "_done_cnt"}, 64'(done_count() - done_before), 64'd1);
  endtask

  initial begin
    logic [47:0] frame;
    logic [47:0] exp;
    int          falls;
    int          oe_bad;
    int          d0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_out", 64'(out1), 64'd1);
    check_eq("rst_oe", 64'(oe1), 64'd0);
    check_eq("rst_busy", 64'(busy1), 64'd0);
    check_eq("rst_done", 64'(done1), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // R7 frame with Ncr = 2
    d0 = done_cnt1;
    send_frame(1'b0, R7_DATA, 1'b0, -1, 0, frame, exp, falls, oe_bad);
    check_eq("r7_falls", 64'(falls), 64'd3);
    check_eq("r7_frame", 64'(frame), 64'(R7_FRAME));
    check_eq("r7_model", 64'(frame), 64'(exp));
    check_eq("r7_oe_held", 64'(oe_bad), 64'd0);
    check_release("r7", d0);

    // Second start while busy is ignored
    d0 = done_cnt1;
    send_frame(1'b0, R7_DATA, 1'b0, 30, 1, frame, exp, falls, oe_bad);
    check_eq("busy_frame", 64'(frame), 64'(R7_FRAME));
    check_eq("busy_oe_held", 64'(oe_bad), 64'd0);
    check_release("busy", d0);
    repeat (3) @(negedge sd_clock);
    #32;
    check_eq("busy_no_extra_done", 64'(done_cnt1 - d0), 64'd1);
    check_eq("busy_idle_after", 64'(busy1), 64'd0);

    // Abort at frame bit 20
    d0 = done_cnt1;
    send_frame(1'b0, {6'd17, 32'h00000900}, 1'b0, 20, 2, frame, exp, falls, oe_bad);
    @(posedge clock);
    #1;
    check_eq("abort_oe", 64'(oe1), 64'd0);
    check_eq("abort_out", 64'(out1), 64'd1);
    check_eq("abort_busy", 64'(busy1), 64'd0);
    check_eq("abort_partial", 64'(frame[47:20]), 64'(exp[47:20]));
    repeat (4) @(negedge sd_clock);
    #32;
    check_eq("abort_no_done", 64'(done_cnt1 - d0), 64'd0);
    check_eq("abort_oe_later", 64'(oe1), 64'd0);
    we = 1'b1;
    repeat (2) @(negedge clock);
    send_frame(1'b0, {6'd17, 32'h00000900}, 1'b0, -1, 0, frame, exp, falls, oe_bad);
    check_eq("post_abort_frame", 64'(frame), 64'(exp));
    check_eq("post_abort_falls", 64'(falls), 64'd3);
    check_release("post_abort", d0);

    // Start while write_enabled low is ignored
    we = 1'b0;
    @(negedge clock);
    start_r = 1'b1;
    @(negedge clock);
    start_r = 1'b0;
    #1;
    check_eq("we0_start_busy", 64'(busy1), 64'd0);
    we = 1'b1;
    repeat (2) @(negedge sd_clock);
    #32;
    check_eq("we0_start_oe", 64'(oe1), 64'd0);

    // Ncr = 0 instance
    sel = 1'b1;
    @(posedge sd_clock);
    #1;
    data    = 38'h2A_DEAD_BEEF;
    start_r = 1'b1;
    @(posedge clock);
    #1;
    start_r = 1'b0;
    check_eq("ncr0_busy_next", 64'(busy2), 64'd1);
    repeat (2) @(negedge sd_clock);
    #32;
    check_eq("ncr0_release_quiet", 64'(busy2), 64'd1);
    repeat (50) @(negedge sd_clock);
    #32;
    check_eq("ncr0_first_idle", 64'(oe2), 64'd0);
    d0 = done_cnt2;
    send_frame(1'b1, {6'd2, 32'h12345678}, 1'b0, -1, 0, frame, exp, falls, oe_bad);
    check_eq("ncr0_falls", 64'(falls), 64'd1);
    check_eq("ncr0_frame", 64'(frame), 64'(exp));
    check_release("ncr0", d0);
    sel = 1'b0;

`ifdef SD_RESP_NO_CRC_EN
    d0 = done_cnt1;
    send_frame(1'b0, R3_DATA, 1'b1, -1, 0, frame, exp, falls, oe_bad);
    check_eq("r3_frame", 64'(frame), 64'(R3_FRAME));
    check_release("r3", d0);
    d0 = done_cnt1;
    send_frame(1'b0, R3_DATA, 1'b0, -1, 0, frame, exp, falls, oe_bad);
    check_eq("r3_crc_frame", 64'(frame), 64'(exp));
    check_eq("r3_crc_end", 64'(frame[0]), 64'd1);
    check_release("r3_crc", d0);
`else
    check_eq("r3_model_sanity", 64'(make_frame(R3_DATA, 1'b1)), 64'(R3_FRAME));
`endif

    // Asynchronous reset in the middle of ST_SEND
    sel = 1'b0;
    @(posedge sd_clock);
    #1;
    data    = R7_DATA;
    start_r = 1'b1;
    @(posedge clock);
    #1;
    start_r = 1'b0;
    repeat (8) @(posedge sd_clock);
    #3;
    check_eq("pre_rst_oe", 64'(oe1), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_oe", 64'(oe1), 64'd0);
    check_eq("mid_rst_out", 64'(out1), 64'd1);
    check_eq("mid_rst_busy", 64'(busy1), 64'd0);
    check_eq("mid_rst_done", 64'(done1), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = done_cnt1;
    repeat (4) @(negedge sd_clock);
    #32;
    check_eq("post_rst_oe", 64'(oe1), 64'd0);
    check_eq("post_rst_busy", 64'(busy1), 64'd0);
    check_eq("post_rst_done", 64'(done_cnt1 - d0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
